fetch_stage: RTL and testbench

- Instruction-fetch stage of the 16-bit pipelined processor.
- Owns the PC and drives the instruction-memory address. Splits each fetched word into op/src/dst fields and registers them into the IF/RR pipeline register consumed by the register-read stage.
- Handles two-word LI: an LI instruction word is followed by a 16-bit immediate word.
- Supports stall from downstream, redirect from the jump/branch unit, and halt from the sys unit.

---
 rtl/fetch_stage.sv | 152 +++++++++++++++
 tb/tb_fetch_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 16-bit pipelined processor.
// Owns the PC and drives the instruction-memory address.
// Decodes each word into op/src/dst fields and registers them into the IF/RR pipeline register.
// Two-word LI instructions are assembled here: the LI word is held internally
// while its 16-bit immediate is fetched on the next cycle.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [3:0]  LI_OPCODE = 4'b1111
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        if_valid,
    output logic [3:0]  if_op,
    output logic [5:0]  if_s,
    output logic [5:0]  if_d,
    output logic [15:0] if_imm,
    output logic        if_is_li,
    output logic [15:0] if_pc
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        IMM    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    fetch_state_e state_r, state_s;
    logic [15:0]  pc_r, pc_s;
    logic [3:0]   hold_op_r, hold_op_s;
    logic [5:0]   hold_s_r, hold_s_s;
    logic [5:0]   hold_d_r, hold_d_s;
    logic [15:0]  hold_pc_r, hold_pc_s;

    logic         valid_s;
    logic [3:0]   op_s;
    logic [5:0]   src_s;
    logic [5:0]   dst_s;
    logic [15:0]  imm_s;
    logic         is_li_s;
    logic [15:0]  out_pc_s;

    // The memory always sees the current PC, even while stalled or halted.
    assign imem_addr = pc_r;

    // Next-state and next-output selection; priority is halt > redirect > stall > fetch.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        hold_op_s = hold_op_r;
        hold_s_s  = hold_s_r;
        hold_d_s  = hold_d_r;
        hold_pc_s = hold_pc_r;
        valid_s   = if_valid;
        op_s      = if_op;
        src_s     = if_s;
        dst_s     = if_d;
        imm_s     = if_imm;
        is_li_s   = if_is_li;
        out_pc_s  = if_pc;

        if (halt || (state_r == HALTED)) begin
            // Halted for good; the fields keep their last values, only valid drops.
            state_s = HALTED;
            valid_s = 1'b0;
        end else if (redirect) begin
            // Squash whatever is in flight, including a half-assembled LI.
            pc_s    = redirect_pc;
            state_s = FETCH;
            valid_s = 1'b0;
        end else if (stall) begin
            // Everything holds; the current word is fetched again later.
            state_s = state_r;
        end else begin
            case (state_r)
                FETCH: begin
                    pc_s = pc_r + 16'd1;
                    if (imem_data[15:12] == LI_OPCODE) begin
                        hold_op_s = imem_data[15:12];
                        hold_s_s  = imem_data[11:6];
                        hold_d_s  = imem_data[5:0];
                        hold_pc_s = pc_r;
                        state_s   = IMM;
                        valid_s   = 1'b0;
                    end else begin
                        op_s     = imem_data[15:12];
                        src_s    = imem_data[11:6];
                        dst_s    = imem_data[5:0];
                        imm_s    = 16'h0000;
                        is_li_s  = 1'b0;
                        out_pc_s = pc_r;
                        valid_s  = 1'b1;
                    end
                end
                IMM: begin
                    op_s     = hold_op_r;
                    src_s    = hold_s_r;
                    dst_s    = hold_d_r;
                    out_pc_s = hold_pc_r;
                    imm_s    = imem_data;
                    is_li_s  = 1'b1;
                    valid_s  = 1'b1;
                    pc_s     = pc_r + 16'd1;
                    state_s  = FETCH;
                end
                default: begin
                    state_s = FETCH;
                    valid_s = 1'b0;
                end
            endcase
        end
    end

    // State, PC, LI holding registers and the IF/RR pipeline register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r   <= FETCH;
            pc_r      <= RESET_PC;
            hold_op_r <= 4'h0;
            hold_s_r  <= 6'd0;
            hold_d_r  <= 6'd0;
            hold_pc_r <= 16'h0000;
            if_valid  <= 1'b0;
            if_op     <= 4'h0;
            if_s      <= 6'd0;
            if_d      <= 6'd0;
            if_imm    <= 16'h0000;
            if_is_li  <= 1'b0;
            if_pc     <= 16'h0000;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            hold_op_r <= hold_op_s;
            hold_s_r  <= hold_s_s;
            hold_d_r  <= hold_d_s;
            hold_pc_r <= hold_pc_s;
            if_valid  <= valid_s;
            if_op     <= op_s;
            if_s      <= src_s;
            if_d      <= dst_s;
            if_imm    <= imm_s;
            if_is_li  <= is_li_s;
            if_pc     <= out_pc_s;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: a main instance at RESET_PC=0 and a
// second instance at RESET_PC=16'hFFFF for the address-wrap LI case.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt = 1'b0;

    logic [15:0] imem_addr, imem_data;
    logic        if_valid, if_is_li;
    logic [3:0]  if_op;
    logic [5:0]  if_s, if_d;
    logic [15:0] if_imm, if_pc;

    logic [15:0] w_addr, w_data;
    logic        w_valid, w_is_li;
    logic [3:0]  w_op;
    logic [5:0]  w_s, w_d;
    logic [15:0] w_imm, w_pc;
    logic        w_stall = 1'b0;
    logic        w_redirect = 1'b0;
    logic [15:0] w_redirect_pc = 16'h0000;
    logic        w_halt = 1'b0;

    logic [15:0] mem  [0:65535];
    logic [15:0] mem2 [0:65535];

    int compared = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    assign imem_data = mem[imem_addr];
    assign w_data    = mem2[w_addr];

    fetch_stage #(.RESET_PC(16'h0000), .LI_OPCODE(4'b1111)) dut (
        .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .if_valid(if_valid), .if_op(if_op), .if_s(if_s), .if_d(if_d),
        .if_imm(if_imm), .if_is_li(if_is_li), .if_pc(if_pc)
    );

    fetch_stage #(.RESET_PC(16'hFFFF), .LI_OPCODE(4'b1111)) dut_wrap (
        .clock(clock), .reset(reset), .imem_addr(w_addr), .imem_data(w_data),
        .stall(w_stall), .redirect(w_redirect), .redirect_pc(w_redirect_pc), .halt(w_halt),
        .if_valid(w_valid), .if_op(w_op), .if_s(w_s), .if_d(w_d),
        .if_imm(w_imm), .if_is_li(w_is_li), .if_pc(w_pc)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle before sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]  = 16'h0000;
            mem2[i] = 16'h0000;
        end
        mem[0]      = 16'h0042;
        mem[4]      = 16'hF005;
        mem[5]      = 16'h1234;
        mem[7]      = 16'h2345;
        mem[8]      = 16'h3000;
        mem[10]     = 16'hF00A;
        mem[11]     = 16'h5555;
        mem[16'h0100] = 16'h4111;
        mem2[16'hFFFF] = 16'hF003;
        mem2[16'h0000] = 16'hBEEF;

        // Reset held for two cycles.
        step();
        check("rst1_valid", {15'd0, if_valid}, 16'd0);
        check("rst1_addr", imem_addr, 16'h0000);
        step();
        check("rst2_valid", {15'd0, if_valid}, 16'd0);
        check("rst2_addr", imem_addr, 16'h0000);
        check("rst2_pc", if_pc, 16'h0000);
        check("rst_wrap_addr", w_addr, 16'hFFFF);

        // First fetch after release.
        reset = 1'b1;
        step();
        check("f0_valid", {15'd0, if_valid}, 16'd1);
        check("f0_op", {12'd0, if_op}, 16'd0);
        check("f0_s", {10'd0, if_s}, 16'd1);
        check("f0_d", {10'd0, if_d}, 16'd2);
        check("f0_pc", if_pc, 16'h0000);
        check("f0_addr", imem_addr, 16'h0001);
        check("wrap_bubble_valid", {15'd0, w_valid}, 16'd0);
        check("wrap_bubble_addr", w_addr, 16'h0000);

        step();
        check("wrap_valid", {15'd0, w_valid}, 16'd1);
        check("wrap_is_li", {15'd0, w_is_li}, 16'd1);
        check("wrap_pc", w_pc, 16'hFFFF);
        check("wrap_imm", w_imm, 16'hBEEF);
        check("wrap_d", {10'd0, w_d}, 16'd3);
        check("wrap_addr", w_addr, 16'h0001);
        check("f1_pc", if_pc, 16'h0001);
        step();
        step();
        check("f3_pc", if_pc, 16'h0003);
        check("f3_addr", imem_addr, 16'h0004);

        // LI at address 4.
        step();
        check("li_bubble_valid", {15'd0, if_valid}, 16'd0);
        check("li_bubble_addr", imem_addr, 16'h0005);
        step();
        check("li_valid", {15'd0, if_valid}, 16'd1);
        check("li_is_li", {15'd0, if_is_li}, 16'd1);
        check("li_op", {12'd0, if_op}, 16'h000F);
        check("li_s", {10'd0, if_s}, 16'd0);
        check("li_d", {10'd0, if_d}, 16'd5);
        check("li_imm", if_imm, 16'h1234);
        check("li_pc", if_pc, 16'h0004);
        check("li_addr", imem_addr, 16'h0006);

        // Plain instruction after LI clears is_li and imm.
        step();
        check("post_li_is_li", {15'd0, if_is_li}, 16'd0);
        check("post_li_imm", if_imm, 16'h0000);
        step();
        check("i7_pc", if_pc, 16'h0007);
        check("i7_addr", imem_addr, 16'h0008);

        // Stall for three cycles.
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_addr", imem_addr, 16'h0008);
            check("stall_valid", {15'd0, if_valid}, 16'd1);
            check("stall_pc", if_pc, 16'h0007);
            check("stall_op", {12'd0, if_op}, 16'd2);
            check("stall_s", {10'd0, if_s}, 16'd13);
            check("stall_d", {10'd0, if_d}, 16'd5);
        end
        stall = 1'b0;
        step();
        check("unstall_pc", if_pc, 16'h0008);
        check("unstall_op", {12'd0, if_op}, 16'd3);
        check("unstall_addr", imem_addr, 16'h0009);

        // Redirect while an LI at 10 waits for its immediate.
        step();
        check("i9_pc", if_pc, 16'h0009);
        step();
        check("li10_bubble", {15'd0, if_valid}, 16'd0);
        check("li10_addr", imem_addr, 16'h000B);
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        step();
        redirect = 1'b0;
        check("redir_valid", {15'd0, if_valid}, 16'd0);
        check("redir_addr", imem_addr, 16'h0100);
        check("redir_pc_held", if_pc, 16'h0009);
        step();
        check("redir_tgt_pc", if_pc, 16'h0100);
        check("redir_tgt_valid", {15'd0, if_valid}, 16'd1);
        check("redir_tgt_is_li", {15'd0, if_is_li}, 16'd0);
        check("redir_tgt_d", {10'd0, if_d}, 16'd17);
        check("redir_tgt_addr", imem_addr, 16'h0101);

        // Redirect wins over a simultaneous stall.
        redirect = 1'b1;
        redirect_pc = 16'h0200;
        stall = 1'b1;
        step();
        redirect = 1'b0;
        stall = 1'b0;
        check("rs_valid", {15'd0, if_valid}, 16'd0);
        check("rs_addr", imem_addr, 16'h0200);
        step();
        check("rs_tgt_pc", if_pc, 16'h0200);
        check("rs_tgt_addr", imem_addr, 16'h0201);

        // Halt together with redirect: halt wins and sticks.
        halt = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'h0300;
        step();
        halt = 1'b0;
        check("halt_valid", {15'd0, if_valid}, 16'd0);
        check("halt_addr", imem_addr, 16'h0201);
        step();
        redirect = 1'b0;
        check("halted_redir_addr", imem_addr, 16'h0201);
        check("halted_redir_valid", {15'd0, if_valid}, 16'd0);
        stall = 1'b1;
        step();
        stall = 1'b0;
        step();
        check("halted_addr", imem_addr, 16'h0201);
        check("halted_valid", {15'd0, if_valid}, 16'd0);

        // Reset leaves HALTED.
        reset = 1'b0;
        step();
        check("rehalt_rst_addr", imem_addr, 16'h0000);
        check("rehalt_rst_valid", {15'd0, if_valid}, 16'd0);
        reset = 1'b1;
        step();
        check("restart_valid", {15'd0, if_valid}, 16'd1);
        check("restart_pc", if_pc, 16'h0000);
        check("restart_s", {10'd0, if_s}, 16'd1);
        check("restart_addr", imem_addr, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
